iic_req_arbiter: RTL and testbench

- Shares one IIC byte driver between two requesters (client 0, client 1) with round-robin arbitration.
- For each granted request: latches the client's command, launches one driver transaction, waits for completion, returns read data and ACK status to that client only.
- Sits between application logic (e.g. EEPROM test, config loader) and the IIC driver; both run from sys_clk, the driver internally on its divided clock.

---
 rtl/iic_req_arbiter.sv | 257 +++++++++++++++++++++++++
 tb/tb_iic_req_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_req_arbiter.sv
// Round-robin arbiter sharing one IIC byte driver between two clients.
// Optional feature macro IIC_RETRY_EN: re-launch a NACKed command up to MAX_RETRY times.
module iic_req_arbiter #(
    parameter int EXEC_HOLD = 64,
    parameter int GAP_CYC   = 200,
    parameter int TIMEOUT   = 1_000_000,
    parameter int MAX_RETRY = 3
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        rh_wl0,
    input  logic        rh_wl1,
    input  logic        bit_ctrl0,
    input  logic        bit_ctrl1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    output logic        done0,
    output logic        done1,
    output logic [7:0]  rdata0,
    output logic [7:0]  rdata1,
    output logic        err0,
    output logic        err1,
    output logic        busy,
    output logic        iic_exec,
    output logic        iic_rh_wl,
    output logic        iic_bit_ctrl,
    output logic [15:0] iic_addr,
    output logic [7:0]  iic_data_w,
    input  logic [7:0]  iic_data_r,
    input  logic        iic_done,
    input  logic        iic_ack
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam int GAP_W = $clog2(GAP_CYC);
    localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(EXEC_HOLD - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP,
        ST_GAP
    } state_t;

    state_t state_reg, state_next;

    logic [CNT_W-1:0] cyc_cnt_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic             last_reg;
    logic             gnt_reg;
    logic             sel_client;
    logic             sel_valid;
    logic             done_s1_reg, done_s2_reg, done_s3_reg;
    logic             cmp_edge;
    logic             resp_fire;
    logic             resp_err;
    logic             retry_take;
    logic             retry_pend;
    logic             busy_reg;
    logic             iic_exec_reg;
    logic             iic_rh_wl_reg;
    logic             iic_bit_ctrl_reg;
    logic [15:0]      iic_addr_reg;
    logic [7:0]       iic_data_w_reg;

    // iic_done comes from the driver's divided clock domain.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            done_s1_reg <= 1'b0;
            done_s2_reg <= 1'b0;
            done_s3_reg <= 1'b0;
        end else begin
            done_s1_reg <= iic_done;
            done_s2_reg <= done_s1_reg;
            done_s3_reg <= done_s2_reg;
        end
    end

    assign cmp_edge = done_s2_reg & ~done_s3_reg;

    always_comb begin
        sel_valid  = req0 | req1;
        sel_client = 1'b0;
        if (req0 && req1) begin
            sel_client = ~last_reg;
        end else if (req1) begin
            sel_client = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The completion edge is only honoured in WAIT, so a late iic_done after
    // a timeout is ignored.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                state_next = sel_valid ? ST_LAUNCH : ST_IDLE;
            end
            ST_LAUNCH: begin
                if (cyc_cnt_reg == EXEC_LAST) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cmp_edge) begin
                    state_next = retry_take ? ST_GAP : ST_RESP;
                end else if (cyc_cnt_reg == TMO_LAST) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = retry_pend ? ST_LAUNCH : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign resp_fire = (state_reg == ST_WAIT) && (state_next == ST_RESP);
    assign resp_err  = cmp_edge ? iic_ack : 1'b1;

`ifdef IIC_RETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 1);

    logic [RW-1:0] retry_cnt_reg;
    logic          retry_pend_reg;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            retry_cnt_reg  <= '0;
            retry_pend_reg <= 1'b0;
        end else if (state_reg == ST_GRANT) begin
            retry_cnt_reg  <= '0;
            retry_pend_reg <= 1'b0;
        end else if ((state_reg == ST_WAIT) && cmp_edge && retry_take) begin
            retry_cnt_reg  <= retry_cnt_reg + 1'b1;
            retry_pend_reg <= 1'b1;
        end else if ((state_reg == ST_GAP) && (state_next == ST_LAUNCH)) begin
            retry_pend_reg <= 1'b0;
        end
    end

    assign retry_take = iic_ack && (retry_cnt_reg < RW'(MAX_RETRY));
    assign retry_pend = retry_pend_reg;
`else
    assign retry_take = 1'b0;
    assign retry_pend = 1'b0;
`endif

    // Cycle counter runs from LAUNCH entry through WAIT; it leaves before TIMEOUT.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            busy_reg         <= 1'b0;
            iic_exec_reg     <= 1'b0;
            last_reg         <= 1'b1;
            gnt_reg          <= 1'b0;
            iic_rh_wl_reg    <= 1'b0;
            iic_bit_ctrl_reg <= 1'b0;
            iic_addr_reg     <= '0;
            iic_data_w_reg   <= '0;
            cyc_cnt_reg      <= '0;
            gap_cnt_reg      <= '0;
        end else begin
            busy_reg     <= (state_next != ST_IDLE);
            iic_exec_reg <= (state_next == ST_LAUNCH);

            if ((state_reg == ST_GRANT) && sel_valid) begin
                gnt_reg          <= sel_client;
                last_reg         <= sel_client;
                iic_rh_wl_reg    <= sel_client ? rh_wl1    : rh_wl0;
                iic_bit_ctrl_reg <= sel_client ? bit_ctrl1 : bit_ctrl0;
                iic_addr_reg     <= sel_client ? addr1     : addr0;
                iic_data_w_reg   <= sel_client ? wdata1    : wdata0;
            end

            if ((state_next == ST_LAUNCH) && (state_reg != ST_LAUNCH)) begin
                cyc_cnt_reg <= '0;
            end else if ((state_next == ST_LAUNCH) || (state_next == ST_WAIT)) begin
                cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
            end

            if ((state_next == ST_GAP) && (state_reg != ST_GAP)) begin
                gap_cnt_reg <= '0;
            end else if (state_next == ST_GAP) begin
                gap_cnt_reg <= gap_cnt_reg + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_client
            localparam logic CID = 1'(gi);

            logic       done_reg;
            logic       err_reg;
            logic [7:0] rdata_reg;

            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    done_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    done_reg <= resp_fire && (gnt_reg == CID);
                    if (resp_fire && (gnt_reg == CID)) begin
                        err_reg <= resp_err;
                        if (iic_rh_wl_reg) begin
                            rdata_reg <= iic_data_r;
                        end
                    end
                end
            end
        end
    endgenerate

    assign done0        = g_client[0].done_reg;
    assign done1        = g_client[1].done_reg;
    assign err0         = g_client[0].err_reg;
    assign err1         = g_client[1].err_reg;
    assign rdata0       = g_client[0].rdata_reg;
    assign rdata1       = g_client[1].rdata_reg;
    assign busy         = busy_reg;
    assign iic_exec     = iic_exec_reg;
    assign iic_rh_wl    = iic_rh_wl_reg;
    assign iic_bit_ctrl = iic_bit_ctrl_reg;
    assign iic_addr     = iic_addr_reg;
    assign iic_data_w   = iic_data_w_reg;

endmodule

// File: tb/tb_iic_req_arbiter.sv
// Directed bench for iic_req_arbiter with a behavioural IIC driver model.
module tb_iic_req_arbiter;

    localparam int EXEC_HOLD = 64;
    localparam int GAP_CYC   = 200;
    localparam int TIMEOUT   = 5000;
    localparam int DRV_LAT   = 100;
    localparam int WAIT_MAX  = 20000;
`ifdef IIC_RETRY_EN
    localparam int NACK_PULSES = 4;
`else
    localparam int NACK_PULSES = 1;
`endif

    typedef struct {
        bit         client;
        bit         rh_wl;
        bit         bit_ctrl;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  mdl_rdata;
        bit         mdl_nack;
        bit         mdl_silent;
        bit         exp_err;
        logic [7:0]  exp_rdata0;
        logic [7:0]  exp_rdata1;
        int         exp_pulses;
    } vec_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        rh_wl0 = 1'b0, rh_wl1 = 1'b0;
    logic        bit_ctrl0 = 1'b0, bit_ctrl1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0;
    logic [7:0]  wdata0 = '0, wdata1 = '0;
    logic        done0, done1, err0, err1, busy;
    logic [7:0]  rdata0, rdata1;
    logic        iic_exec, iic_rh_wl, iic_bit_ctrl;
    logic [15:0] iic_addr;
    logic [7:0]  iic_data_w;
    logic [7:0]  iic_data_r;
    logic        iic_done, iic_ack;

    int n_total = 0;
    int n_pass  = 0;

    iic_req_arbiter #(
        .EXEC_HOLD (EXEC_HOLD),
        .GAP_CYC   (GAP_CYC),
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (3)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .req0         (req0),
        .req1         (req1),
        .rh_wl0       (rh_wl0),
        .rh_wl1       (rh_wl1),
        .bit_ctrl0    (bit_ctrl0),
        .bit_ctrl1    (bit_ctrl1),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .done0        (done0),
        .done1        (done1),
        .rdata0       (rdata0),
        .rdata1       (rdata1),
        .err0         (err0),
        .err1         (err1),
        .busy         (busy),
        .iic_exec     (iic_exec),
        .iic_rh_wl    (iic_rh_wl),
        .iic_bit_ctrl (iic_bit_ctrl),
        .iic_addr     (iic_addr),
        .iic_data_w   (iic_data_w),
        .iic_data_r   (iic_data_r),
        .iic_done     (iic_done),
        .iic_ack      (iic_ack)
    );

    always #5 sys_clk = ~sys_clk;

    // Monitor: exec pulses, exec width, command at exec rise, done pulses.
    int          cyc_now = 0;
    int          exec_pulses = 0;
    int          exec_rise_cyc = 0;
    int          exec_run = 0;
    int          last_width = 0;
    int          done0_cnt = 0;
    int          done1_cnt = 0;
    int          last_done_cyc = 0;
    logic        exec_mon_d = 1'b0;
    logic [15:0] cap_addr = '0;
    logic        cap_bc = 1'b0;
    logic        cap_rw = 1'b0;
    logic [7:0]  cap_wd = '0;

    always @(posedge sys_clk) begin
        cyc_now    <= cyc_now + 1;
        exec_mon_d <= iic_exec;
        exec_run   <= iic_exec ? exec_run + 1 : 0;
        if (iic_exec && !exec_mon_d) begin
            exec_pulses   <= exec_pulses + 1;
            exec_rise_cyc <= cyc_now;
            cap_addr      <= iic_addr;
            cap_bc        <= iic_bit_ctrl;
            cap_rw        <= iic_rh_wl;
            cap_wd        <= iic_data_w;
        end
        if (!iic_exec && exec_mon_d) last_width <= exec_run;
        if (done0) begin
            done0_cnt     <= done0_cnt + 1;
            last_done_cyc <= cyc_now;
        end
        if (done1) begin
            done1_cnt     <= done1_cnt + 1;
            last_done_cyc <= cyc_now;
        end
    end

    // Driver model: answers DRV_LAT cycles after exec rises, done held 8 cycles.
    logic       mdl_nack = 1'b0;
    logic       mdl_silent = 1'b0;
    logic [7:0] mdl_rdata = '0;
    logic       drv_exec_d;
    logic       drv_on;
    int         drv_cnt;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            drv_exec_d <= 1'b0;
            drv_on     <= 1'b0;
            drv_cnt    <= 0;
            iic_done   <= 1'b0;
            iic_ack    <= 1'b0;
            iic_data_r <= '0;
        end else begin
            drv_exec_d <= iic_exec;
            if (iic_exec && !drv_exec_d) begin
                drv_on  <= !mdl_silent;
                drv_cnt <= 0;
            end else if (drv_on) begin
                drv_cnt <= drv_cnt + 1;
                if (drv_cnt == DRV_LAT) begin
                    iic_done   <= 1'b1;
                    iic_ack    <= mdl_nack;
                    iic_data_r <= mdl_rdata;
                end
                if (drv_cnt == DRV_LAT + 8) begin
                    iic_done <= 1'b0;
                    drv_on   <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < WAIT_MAX; k++) begin
            @(negedge sys_clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, " idle reached"}, 32'(ok), 32'd1);
        @(negedge sys_clk);
    endtask

    function automatic vec_t mk(bit c, bit rw, bit bc, logic [15:0] a, logic [7:0] wd,
                                logic [7:0] mrd, bit nack, bit silent, bit e,
                                logic [7:0] r0, logic [7:0] r1, int p);
        vec_t v;
        v.client = c; v.rh_wl = rw; v.bit_ctrl = bc; v.addr = a; v.wdata = wd;
        v.mdl_rdata = mrd; v.mdl_nack = nack; v.mdl_silent = silent;
        v.exp_err = e; v.exp_rdata0 = r0; v.exp_rdata1 = r1; v.exp_pulses = p;
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input int idx);
        string nm;
        int    p0, d0, d1;
        bit    ok;
        nm = $sformatf("v%0d", idx);
        mdl_rdata  = v.mdl_rdata;
        mdl_nack   = v.mdl_nack;
        mdl_silent = v.mdl_silent;
        @(negedge sys_clk);
        p0 = exec_pulses; d0 = done0_cnt; d1 = done1_cnt;
        if (!v.client) begin
            rh_wl0 = v.rh_wl; bit_ctrl0 = v.bit_ctrl; addr0 = v.addr; wdata0 = v.wdata; req0 = 1'b1;
        end else begin
            rh_wl1 = v.rh_wl; bit_ctrl1 = v.bit_ctrl; addr1 = v.addr; wdata1 = v.wdata; req1 = 1'b1;
        end
        ok = 1'b0;
        for (int k = 0; k < WAIT_MAX; k++) begin
            @(negedge sys_clk);
            if (v.client ? done1 : done0) begin
                ok = 1'b1;
                break;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk({nm, " done seen"}, 32'(ok), 32'd1);
        chk({nm, " err"}, 32'(v.client ? err1 : err0), 32'(v.exp_err));
        chk({nm, " rdata0"}, 32'(rdata0), 32'(v.exp_rdata0));
        chk({nm, " rdata1"}, 32'(rdata1), 32'(v.exp_rdata1));
        chk({nm, " cmd addr"}, 32'(iic_addr), 32'(v.addr));
        wait_idle(nm);
        chk({nm, " own done count"}, 32'(v.client ? done1_cnt - d1 : done0_cnt - d0), 32'd1);
        chk({nm, " other done count"}, 32'(v.client ? done0_cnt - d0 : done1_cnt - d1), 32'd0);
        chk({nm, " exec pulses"}, 32'(exec_pulses - p0), 32'(v.exp_pulses));
        chk({nm, " exec width"}, 32'(last_width), 32'(EXEC_HOLD));
        chk({nm, " drv addr"}, 32'(cap_addr), 32'(v.addr));
        chk({nm, " drv bit_ctrl"}, 32'(cap_bc), 32'(v.bit_ctrl));
        chk({nm, " drv rh_wl"}, 32'(cap_rw), 32'(v.rh_wl));
        chk({nm, " drv wdata"}, 32'(cap_wd), 32'(v.wdata));
        if (v.mdl_silent)
            chk({nm, " timeout latency"}, 32'(last_done_cyc - exec_rise_cyc), 32'(TIMEOUT));
        $display("txn %s client %0d rw %0d addr %04h err %0d rdata0 %02h rdata1 %02h pulses %0d",
                 nm, v.client, v.rh_wl, v.addr, v.client ? err1 : err0, rdata0, rdata1,
                 exec_pulses - p0);
    endtask

    vec_t vecs[8];

    initial begin
        bit ok;
        int who;
        int t_done;
        int d0;

        vecs[0] = mk(1'b0, 1'b0, 1'b1, 16'h0010, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1);
        vecs[1] = mk(1'b1, 1'b1, 1'b1, 16'h0010, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 8'h5A, 1);
        vecs[2] = mk(1'b0, 1'b1, 1'b1, 16'h1234, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h5A, 1);
        vecs[3] = mk(1'b1, 1'b0, 1'b0, 16'h00FF, 8'h77, 8'hEE, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h5A, 1);
        vecs[4] = mk(1'b0, 1'b0, 1'b0, 16'h0050, 8'h66, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 8'h5A, NACK_PULSES);
        vecs[5] = mk(1'b0, 1'b1, 1'b0, 16'h0051, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b0, 8'hC3, 8'h5A, 1);
        vecs[6] = mk(1'b0, 1'b0, 1'b1, 16'h0100, 8'h12, 8'h00, 1'b0, 1'b1, 1'b1, 8'hC3, 8'h5A, 1);
        vecs[7] = mk(1'b1, 1'b1, 1'b1, 16'hFFFF, 8'h00, 8'h42, 1'b0, 1'b0, 1'b0, 8'hC3, 8'h42, 1);

        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst exec", 32'(iic_exec), 32'd0);
        chk("rst done", 32'({done1, done0}), 32'd0);
        chk("rst err", 32'({err1, err0}), 32'd0);
        chk("rst rdata", 32'({rdata1, rdata0}), 32'd0);
        chk("rst cmd", 32'({iic_rh_wl, iic_bit_ctrl, iic_data_w, iic_addr}), 32'd0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Simultaneous requests held for four transactions: 0,1,0,1
        mdl_nack = 1'b0; mdl_silent = 1'b0; mdl_rdata = 8'h00;
        rh_wl0 = 1'b0; bit_ctrl0 = 1'b1; addr0 = 16'h0100; wdata0 = 8'h01;
        rh_wl1 = 1'b0; bit_ctrl1 = 1'b0; addr1 = 16'h0200; wdata1 = 8'h02;
        req0 = 1'b1; req1 = 1'b1;
        for (int t = 0; t < 4; t++) begin
            ok = 1'b0;
            for (int k = 0; k < WAIT_MAX; k++) begin
                @(negedge sys_clk);
                if (done0 || done1) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk($sformatf("alt%0d done seen", t), 32'(ok), 32'd1);
            who = done1 ? 1 : 0;
            chk($sformatf("alt%0d order", t), 32'(who), 32'(t % 2));
            if (t == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end else begin
                t_done = cyc_now;
                ok = 1'b0;
                for (int k = 0; k < WAIT_MAX; k++) begin
                    @(negedge sys_clk);
                    if (iic_exec) begin
                        ok = 1'b1;
                        break;
                    end
                end
                chk($sformatf("alt%0d gap", t), 32'(ok && (cyc_now - t_done >= GAP_CYC)), 32'd1);
            end
            $display("alt txn %0d client %0d", t, who);
        end
        wait_idle("alt");

        // Latency: request accepted to iic_exec high in 2 cycles
        mdl_nack = 1'b0; mdl_silent = 1'b0;
        rh_wl0 = 1'b0; bit_ctrl0 = 1'b0; addr0 = 16'h0033; wdata0 = 8'h44;
        req0 = 1'b1;
        @(posedge sys_clk); #1;
        chk("lat busy after 1", 32'(busy), 32'd1);
        chk("lat exec after 1", 32'(iic_exec), 32'd0);
        @(posedge sys_clk); #1;
        chk("lat exec after 2", 32'(iic_exec), 32'd1);
        ok = 1'b0;
        for (int k = 0; k < WAIT_MAX; k++) begin
            @(negedge sys_clk);
            if (done0) begin
                ok = 1'b1;
                break;
            end
        end
        req0 = 1'b0;
        chk("lat done seen", 32'(ok), 32'd1);
        $display("lat txn client 0 addr %04h", iic_addr);
        wait_idle("lat");

        for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

        // Reset pulsed during WAIT
        mdl_nack = 1'b0; mdl_silent = 1'b0; mdl_rdata = 8'h77;
        @(negedge sys_clk);
        rh_wl0 = 1'b1; bit_ctrl0 = 1'b1; addr0 = 16'h2000; req0 = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < WAIT_MAX; k++) begin
            @(negedge sys_clk);
            if (iic_exec) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rstw exec rise", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int k = 0; k < WAIT_MAX; k++) begin
            @(negedge sys_clk);
            if (!iic_exec) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rstw exec fall", 32'(ok), 32'd1);
        repeat (10) @(negedge sys_clk);
        chk("rstw busy before", 32'(busy), 32'd1);
        d0 = done0_cnt;
        sys_rst_n = 1'b0;
        req0 = 1'b0;
        #1;
        chk("rstw busy", 32'(busy), 32'd0);
        chk("rstw exec", 32'(iic_exec), 32'd0);
        chk("rstw rdata", 32'({rdata1, rdata0}), 32'd0);
        chk("rstw done err", 32'({done1, done0, err1, err0}), 32'd0);
        chk("rstw cmd", 32'({iic_rh_wl, iic_bit_ctrl, iic_data_w, iic_addr}), 32'd0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (300) @(negedge sys_clk);
        chk("rstw no done", 32'(done0_cnt - d0), 32'd0);
        chk("rstw idle", 32'(busy), 32'd0);
        $display("rst txn client 0 aborted, done pulses %0d", done0_cnt - d0);

        run_txn(mk(1'b1, 1'b0, 1'b1, 16'h0ABC, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1), 8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
